// File: rtl/arb_rr8_decoded.sv
// arb_rr8_decoded: 8-way round-robin arbiter with registered one-hot grant and owner index.
// Optional hold-time revocation when ARB_TIMEOUT_EN is defined (limit MAX_HOLD cycles).
module arb_rr8_decoded #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       e,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state;
    logic [2:0] ptr;
    logic [2:0] pick;
    logic       rel;
    logic       expire;
    // Scan downward so the last hit is the one closest to ptr.
    always_comb begin
        pick = ptr;
        for (int k = 7; k >= 0; k--)
            if (req[ptr + 3'(k)]) pick = ptr + 3'(k);
    end
    assign rel = done | ~req[gnt_idx];
`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt;
    assign expire = state == GRANT && cnt == 8'(MAX_HOLD - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= 8'd0;
        else cnt <= (state == GRANT) ? cnt + 8'd1 : 8'd0;
`else
    assign expire = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= 3'd0;
            gnt     <= 8'h00;
            gnt_idx <= 3'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == IDLE) begin
                if (e && |req) begin
                    state   <= GRANT;
                    gnt_idx <= pick;
                    gnt     <= 8'h01 << pick;
                    busy    <= 1'b1;
                end
            end else if (rel || expire) begin
                state   <= IDLE;
                gnt     <= 8'h00;
                busy    <= 1'b0;
                ptr     <= gnt_idx + 3'd1;
                timeout <= expire & ~rel;
            end
        end
    end
endmodule

// File: tb/tb_arb_rr8_decoded.sv
// tb_arb_rr8_decoded: directed plus randomized checks of arb_rr8_decoded against a behavioural model.
// Build with or without ARB_TIMEOUT_EN; the model follows the same macro.
module tb_arb_rr8_decoded;
    localparam int MH = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       e = 1'b1;
    logic [7:0] req = 8'hFF;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       timeout;
    int pass_cnt = 0;
    int tot_cnt = 0;

    arb_rr8_decoded #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .e(e), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: owner held (m_busy), cycles visible so far (m_held), next-search start (m_ptr).
    int m_busy = 0, m_idx = 0, m_ptr = 0, m_held = 0, m_to = 0;

    function automatic int first_from(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_idx <= 0; m_ptr <= 0; m_held <= 0; m_to <= 0;
        end else if (m_busy == 0) begin
            m_to <= 0;
            if (e && req != 8'h00) begin
                m_busy <= 1;
                m_idx  <= first_from(req, m_ptr);
                m_held <= 1;
            end
        end else begin
            automatic bit normal = done || !req[m_idx];
            automatic bit expired = 0;
`ifdef ARB_TIMEOUT_EN
            expired = m_held >= MH;
`endif
            if (normal || expired) begin
                m_busy <= 0;
                m_ptr  <= (m_idx + 1) % 8;
                m_to   <= (expired && !normal) ? 1 : 0;
            end else begin
                m_held <= m_held + 1;
                m_to   <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt", int'(gnt), m_busy ? (1 << m_idx) : 0);
        chk("gnt_idx", int'(gnt_idx), m_idx);
        chk("busy", int'(busy), m_busy);
        chk("timeout", int'(timeout), m_to);
        chk("onehot", int'($countones(gnt) <= 1), 1);
    end

    task automatic step(input logic [7:0] r, input logic en, input logic d);
        #1;
        req = r; e = en; done = d;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [7:0] g, input logic b);
        chk({name, "_gnt"}, int'(gnt), int'(g));
        chk({name, "_busy"}, int'(busy), int'(b));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        lit("in_reset", 8'h00, 1'b0);
        chk("in_reset_idx", int'(gnt_idx), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        lit("first_grant", 8'h01, 1'b1);
        chk("first_idx", int'(gnt_idx), 0);
        for (int k = 1; k <= 8; k++) begin
            step(8'hFF, 1'b1, 1'b1);
            lit("rr_dead", 8'h00, 1'b0);
            step(8'hFF, 1'b1, 1'b0);
            lit("rr_grant", 8'h01 << (k % 8), 1'b1);
        end
        step(8'hFF, 1'b1, 1'b1);  lit("skip_a", 8'h00, 1'b0);
        step(8'h20, 1'b1, 1'b0);  lit("skip_b", 8'h20, 1'b1);
        step(8'h20, 1'b1, 1'b1);  lit("skip_c", 8'h00, 1'b0);
        step(8'h21, 1'b1, 1'b0);  lit("skip_wrap", 8'h01, 1'b1);
        step(8'h21, 1'b1, 1'b1);  lit("skip_d", 8'h00, 1'b0);
        step(8'h21, 1'b1, 1'b0);  lit("skip_five", 8'h20, 1'b1);
        step(8'h21, 1'b1, 1'b1);  lit("skip_e", 8'h00, 1'b0);
        step(8'h10, 1'b0, 1'b0);  lit("en_off", 8'h00, 1'b0);
        step(8'h10, 1'b0, 1'b1);  lit("en_off_done", 8'h00, 1'b0);
        step(8'h10, 1'b1, 1'b0);  lit("en_on", 8'h10, 1'b1);
        step(8'h10, 1'b0, 1'b0);  lit("en_drop_held", 8'h10, 1'b1);
        step(8'h18, 1'b0, 1'b0);  lit("other_req", 8'h10, 1'b1);
        step(8'h00, 1'b0, 1'b0);  lit("withdraw", 8'h00, 1'b0);
        step(8'h04, 1'b1, 1'b0);  lit("pre_rst", 8'h04, 1'b1);
        #2 rst_n = 1'b0;
        #1 lit("async_rst", 8'h00, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(8'h08, 1'b1, 1'b0);  lit("hold_1", 8'h08, 1'b1);
        step(8'h08, 1'b1, 1'b0);  lit("hold_2", 8'h08, 1'b1);
        step(8'h08, 1'b1, 1'b0);  lit("hold_3", 8'h08, 1'b1);
        step(8'h08, 1'b1, 1'b0);  lit("hold_4", 8'h08, 1'b1);
`ifdef ARB_TIMEOUT_EN
        step(8'h08, 1'b1, 1'b0);  lit("to_dead", 8'h00, 1'b0);
        chk("to_pulse", int'(timeout), 1);
        step(8'h08, 1'b1, 1'b0);  lit("to_regrant", 8'h08, 1'b1);
        chk("to_clear", int'(timeout), 0);
`else
        step(8'h08, 1'b1, 1'b0);  lit("hold_5", 8'h08, 1'b1);
        chk("no_timeout", int'(timeout), 0);
`endif
        step(8'h08, 1'b1, 1'b1);  lit("done_rel", 8'h00, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            automatic logic [7:0] r = 8'($urandom) & 8'($urandom | $urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
            step($urandom_range(0, 9) < 8 ? (req | r) & 8'($urandom | $urandom) : r,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0);
        end
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
